harmonic_sequencer: RTL and testbench

//  Initiator side of the scaled-sample Adder protocol. On each output-sample tick it walks harmonics 1..N.
//  Per harmonic: reads a sine LUT at phase*(h), presents sample plus level to the Adder, pulses start and awaits done.

---
 rtl/harmonic_sequencer_pkg.sv | 70 +++++++
 rtl/harmonic_sequencer_sine_rom.sv | 35 +++
 rtl/harmonic_sequencer.sv | 172 +++++++++++++++++
 tb/tb_harmonic_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/harmonic_sequencer_pkg.sv
// Shared types, widths and helpers for the harmonic sequencer.
//   state_t    : sweep FSM encoding
//   sat16      : arithmetic shift plus 16-bit signed saturation
//   sine_entry : elaboration-time sine table entry, round(32767*sin(2*pi*k/2^bits))
package harmonic_sequencer_pkg;

  localparam int unsigned DIVISOR_BITS_DEF = 11;
  localparam int unsigned SINE_BITS_DEF    = 10;
  localparam int unsigned HARMONICS_DEF    = 64;
  localparam int unsigned OUT_SHIFT_DEF    = 6;

  localparam int unsigned SAMPLE_W    = 16;
  localparam int unsigned PHASE_W     = 32;
  localparam int unsigned ACC_W       = 32;
  localparam int unsigned NYQUIST_BIT = 31;

  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = 16'sh8000;

  // pi scaled by 2^40
  localparam longint PI_Q40 = 64'sd3454217652358;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FETCH,
    ST_START,
    ST_ARM,
    ST_WAIT,
    ST_OUTPUT
  } state_t;

  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [ACC_W-1:0] acc,
                                                       input int unsigned shift);
    logic signed [ACC_W-1:0] shifted;
    shifted = acc >>> shift;
    if (shifted > 32'sd32767)
      return SAMPLE_MAX;
    else if (shifted < -32'sd32768)
      return SAMPLE_MIN;
    else
      return SAMPLE_W'(shifted);
  endfunction

  // Quarter-wave folded Taylor series in Q30 fixed point; only evaluated at elaboration.
  function automatic logic signed [SAMPLE_W-1:0] sine_entry(input int unsigned k,
                                                            input int unsigned bits);
    longint n, half, quarter, r, x, x2, term, s, v;
    logic   neg;
    n       = longint'(1) << bits;
    half    = n >> 1;
    quarter = n >> 2;
    r       = longint'(k) % n;
    neg     = (r >= half);
    if (neg) r = r - half;
    if (r > quarter) r = half - r;
    x    = (r * PI_Q40) / (half << 10);
    x2   = (x * x) >>> 30;
    term = x;
    s    = x;
    for (int i = 1; i <= 9; i++) begin
      term = -((term * x2) >>> 30) / longint'((2 * i) * (2 * i + 1));
      s    = s + term;
    end
    v = (s * 32767 + (longint'(1) << 29)) >>> 30;
    if (neg) v = -v;
    return SAMPLE_W'(v);
  endfunction

endpackage

// File: rtl/harmonic_sequencer_sine_rom.sv
// Full-cycle sine lookup table with a registered one-cycle read.
//   i_Clock, i_Reset : clock, synchronous active-high reset (clears the read register)
//   i_Rd_En          : load the read register from i_Addr
//   i_Addr           : table index (2^SINE_BITS entries)
//   o_Data           : signed 16-bit sample, valid the cycle after i_Rd_En
module harmonic_sequencer_sine_rom
  import harmonic_sequencer_pkg::*;
#(
  parameter int unsigned SINE_BITS = SINE_BITS_DEF
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset,
  input  logic                       i_Rd_En,
  input  logic [SINE_BITS-1:0]       i_Addr,
  output logic signed [SAMPLE_W-1:0] o_Data
);

  localparam int unsigned DEPTH = 1 << SINE_BITS;

  logic signed [SAMPLE_W-1:0] rom [DEPTH];

  // Table contents are constants computed at elaboration.
  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam logic signed [SAMPLE_W-1:0] ENTRY = sine_entry(k, SINE_BITS);
    assign rom[k] = ENTRY;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset)
      o_Data <= '0;
    else if (i_Rd_En)
      o_Data <= rom[i_Addr];
  end

endmodule

// File: rtl/harmonic_sequencer.sv
// Additive-synthesis sweep: per sample tick, drives harmonics 1..N through the
// external scaled-sample Adder and saturates the accumulated total to 16 bits.
//   i_Clock, i_Reset         : clock, synchronous active-high reset
//   i_Sample_Tick            : start a new output sample
//   i_Phase, i_Phase_Inc     : fundamental phase / per-sample increment (latched at tick)
//   i_Level_Start/Step       : harmonic-1 level and per-harmonic decrement (latched at tick)
//   o_Adder_Sample/Multiple  : operands to the Adder
//   o_Adder_Start/Clear      : one-cycle Adder controls
//   i_Adder_Done, i_Accumulator : Adder status and running total
//   o_Sample, o_Sample_Valid : saturated output sample and its strobe
//   o_Overrun                : tick arrived while a sweep was in progress
module harmonic_sequencer
  import harmonic_sequencer_pkg::*;
#(
  parameter int unsigned DIVISOR_BITS = DIVISOR_BITS_DEF,
  parameter int unsigned SINE_BITS    = SINE_BITS_DEF,
  parameter int unsigned HARMONICS    = HARMONICS_DEF,
  parameter int unsigned OUT_SHIFT    = OUT_SHIFT_DEF
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset,
  input  logic                       i_Sample_Tick,
  input  logic [PHASE_W-1:0]         i_Phase,
  input  logic [PHASE_W-1:0]         i_Phase_Inc,
  input  logic [DIVISOR_BITS-1:0]    i_Level_Start,
  input  logic [DIVISOR_BITS-1:0]    i_Level_Step,
  output logic signed [SAMPLE_W-1:0] o_Adder_Sample,
  output logic [DIVISOR_BITS-1:0]    o_Adder_Multiple,
  output logic                       o_Adder_Start,
  output logic                       o_Adder_Clear,
  input  logic                       i_Adder_Done,
  input  logic signed [ACC_W-1:0]    i_Accumulator,
  output logic signed [SAMPLE_W-1:0] o_Sample,
  output logic                       o_Sample_Valid,
  output logic                       o_Overrun
);

  localparam int unsigned H_BITS = $clog2(HARMONICS + 2);

  state_t                     state, state_d;
  logic [PHASE_W-1:0]         phase, phase_d;
  logic [PHASE_W-1:0]         inc, inc_d;
  logic [DIVISOR_BITS-1:0]    step, step_d;
  logic [DIVISOR_BITS-1:0]    level, level_d;
  logic [PHASE_W-1:0]         harm_phase, harm_phase_d;
  logic [PHASE_W:0]           harm_inc, harm_inc_d;
  logic [H_BITS-1:0]          h, h_d;
  logic [DIVISOR_BITS-1:0]    multiple_d;
  logic                       start_d, clear_d, valid_d, overrun_d;
  logic signed [SAMPLE_W-1:0] sample_d;

  // Per-harmonic advance, applied when the Adder reports done.
  logic [PHASE_W-1:0]      upd_phase;
  logic [PHASE_W:0]        upd_inc;
  logic [DIVISOR_BITS-1:0] upd_level;
  logic [H_BITS-1:0]       upd_h;
  logic                    cont_now, cont_upd;

  assign upd_phase = harm_phase + phase;
  assign upd_inc   = harm_inc + {1'b0, inc};
  assign upd_level = (level > step) ? level - step : '0;
  assign upd_h     = h + H_BITS'(1);

  // Stop on harmonic cap, silent level, or harmonic frequency at/above Nyquist.
  assign cont_now = (h <= H_BITS'(HARMONICS)) && (level != '0) &&
                    (harm_inc[PHASE_W:NYQUIST_BIT] == '0);
  assign cont_upd = (upd_h <= H_BITS'(HARMONICS)) && (upd_level != '0) &&
                    (upd_inc[PHASE_W:NYQUIST_BIT] == '0);

  harmonic_sequencer_sine_rom #(
    .SINE_BITS (SINE_BITS)
  ) u_sine_rom (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Rd_En (state == ST_FETCH),
    .i_Addr  (harm_phase[PHASE_W-1 -: SINE_BITS]),
    .o_Data  (o_Adder_Sample)
  );

  // Next-state and next-output logic; outputs are registered to line up with the state they belong to.
  always_comb begin
    state_d      = state;
    phase_d      = phase;
    inc_d        = inc;
    step_d       = step;
    level_d      = level;
    harm_phase_d = harm_phase;
    harm_inc_d   = harm_inc;
    h_d          = h;
    multiple_d   = o_Adder_Multiple;
    sample_d     = o_Sample;
    start_d      = 1'b0;
    clear_d      = 1'b0;
    valid_d      = 1'b0;
    overrun_d    = i_Sample_Tick && (state != ST_IDLE);

    case (state)
      ST_IDLE: begin
        if (i_Sample_Tick) begin
          phase_d      = i_Phase;
          inc_d        = i_Phase_Inc;
          step_d       = i_Level_Step;
          level_d      = i_Level_Start;
          harm_phase_d = i_Phase;
          harm_inc_d   = {1'b0, i_Phase_Inc};
          h_d          = H_BITS'(1);
          clear_d      = 1'b1;
          state_d      = ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = cont_now ? ST_FETCH : ST_OUTPUT;
      ST_FETCH: begin
        multiple_d = level;
        start_d    = 1'b1;
        state_d    = ST_START;
      end
      ST_START: state_d = ST_ARM;
      // Guard cycle: done may still be high from the previous harmonic.
      ST_ARM:   state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_Adder_Done) begin
          harm_phase_d = upd_phase;
          harm_inc_d   = upd_inc;
          level_d      = upd_level;
          h_d          = upd_h;
          state_d      = cont_upd ? ST_FETCH : ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        sample_d = sat16(i_Accumulator, OUT_SHIFT);
        valid_d  = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state            <= ST_IDLE;
      phase            <= '0;
      inc              <= '0;
      step             <= '0;
      level            <= '0;
      harm_phase       <= '0;
      harm_inc         <= '0;
      h                <= '0;
      o_Adder_Multiple <= '0;
      o_Adder_Start    <= 1'b0;
      o_Adder_Clear    <= 1'b0;
      o_Sample         <= '0;
      o_Sample_Valid   <= 1'b0;
      o_Overrun        <= 1'b0;
    end else begin
      state            <= state_d;
      phase            <= phase_d;
      inc              <= inc_d;
      step             <= step_d;
      level            <= level_d;
      harm_phase       <= harm_phase_d;
      harm_inc         <= harm_inc_d;
      h                <= h_d;
      o_Adder_Multiple <= multiple_d;
      o_Adder_Start    <= start_d;
      o_Adder_Clear    <= clear_d;
      o_Sample         <= sample_d;
      o_Sample_Valid   <= valid_d;
      o_Overrun        <= overrun_d;
    end
  end

endmodule

// File: tb/tb_harmonic_sequencer.sv
// Bench for harmonic_sequencer with a behavioural scaled-sample Adder:
// acc += (sample * multiple) >>> DIVISOR_BITS, done two cycles after start.
module tb_harmonic_sequencer;

  localparam int unsigned DIV = 11;
  localparam int NV = 7;

  typedef struct {
    logic [31:0]    phase;
    logic [31:0]    inc;
    logic [DIV-1:0] lstart;
    logic [DIV-1:0] lstep;
    int             exp_starts;
    int             exp_lat;
    int             exp_sample;
  } vec_t;

  logic clk = 1'b0;
  logic rst, tick;
  logic [31:0] phase, inc;
  logic [DIV-1:0] lstart, lstep;
  logic signed [15:0] a_samp;
  logic [DIV-1:0] a_mult;
  logic a_start, a_clear, a_done;
  logic signed [31:0] acc_in;
  logic signed [15:0] samp;
  logic samp_valid, overrun;

  always #5 clk = ~clk;

  harmonic_sequencer dut (
    .i_Clock          (clk),
    .i_Reset          (rst),
    .i_Sample_Tick    (tick),
    .i_Phase          (phase),
    .i_Phase_Inc      (inc),
    .i_Level_Start    (lstart),
    .i_Level_Step     (lstep),
    .o_Adder_Sample   (a_samp),
    .o_Adder_Multiple (a_mult),
    .o_Adder_Start    (a_start),
    .o_Adder_Clear    (a_clear),
    .i_Adder_Done     (a_done),
    .i_Accumulator    (acc_in),
    .o_Sample         (samp),
    .o_Sample_Valid   (samp_valid),
    .o_Overrun        (overrun)
  );

  // Adder model, with an override for saturation tests.
  logic signed [31:0] acc_model, force_val;
  logic force_en, busy;
  logic signed [15:0] cap_s;
  logic [DIV-1:0] cap_m;

  assign acc_in = force_en ? force_val : acc_model;

  always @(posedge clk) begin
    if (rst) begin
      acc_model <= '0;
      a_done    <= 1'b0;
      busy      <= 1'b0;
      cap_s     <= '0;
      cap_m     <= '0;
    end else begin
      if (a_clear) acc_model <= '0;
      if (a_start) begin
        busy   <= 1'b1;
        a_done <= 1'b0;
        cap_s  <= a_samp;
        cap_m  <= a_mult;
      end else if (busy) begin
        acc_model <= acc_model + 32'((longint'(cap_s) * longint'(cap_m)) >>> DIV);
        a_done    <= 1'b1;
        busy      <= 1'b0;
      end
    end
  end

  // Cycle counter and output monitor (samples 2 ns after the active edge).
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int start_cnt = 0, valid_cnt = 0, ovr_cnt = 0, valid_cyc = 0, ovr_cyc = 0;
  logic signed [15:0] valid_samp;
  logic signed [15:0] start_samp [1024];
  logic [DIV-1:0]     start_mult [1024];

  always @(posedge clk) begin
    #2;
    if (a_start) begin
      if (start_cnt < 1024) begin
        start_samp[10'(start_cnt)] = a_samp;
        start_mult[10'(start_cnt)] = a_mult;
      end
      start_cnt++;
    end
    if (samp_valid) begin
      valid_cnt++;
      valid_cyc  = cyc;
      valid_samp = samp;
    end
    if (overrun) begin
      ovr_cnt++;
      ovr_cyc = cyc;
    end
  end

  int checks = 0, errors = 0;
  int t0, base_s, base_v, base_o;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_tick(input logic [31:0] ph, input logic [31:0] pi,
                            input logic [DIV-1:0] ls, input logic [DIV-1:0] st);
    @(negedge clk);
    phase  = ph;
    inc    = pi;
    lstart = ls;
    lstep  = st;
    tick   = 1'b1;
    base_s = start_cnt;
    base_v = valid_cnt;
    base_o = ovr_cnt;
    t0     = cyc;
    @(negedge clk);
    tick = 1'b0;
  endtask

  // Bounded wait for the valid strobe, then a few idle cycles to catch extras.
  task automatic wait_valid();
    int n = 0;
    while (valid_cnt == base_v && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " adder_sample"}, a_samp, 0);
    chk({tag, " adder_multiple"}, a_mult, 0);
    chk({tag, " adder_start"}, a_start, 0);
    chk({tag, " adder_clear"}, a_clear, 0);
    chk({tag, " sample"}, samp, 0);
    chk({tag, " sample_valid"}, samp_valid, 0);
    chk({tag, " overrun"}, overrun, 0);
  endtask

  initial begin
    vec_t vecs [NV];
    logic signed [15:0] pat [7];
    int t2;
    int n;

    vecs[0] = '{32'h4000_0000, 32'h0100_0000, 11'd2047, 11'd2047, 1,   7,  511};
    vecs[1] = '{32'h4000_0000, 32'h1000_0000, 11'd1024, 11'd0,    7,  31,   -1};
    vecs[2] = '{32'h4000_0000, 32'h0000_1000, 11'd1024, 11'd0,   64, 259,   -1};
    vecs[3] = '{32'h4000_0000, 32'h8000_0000, 11'd1024, 11'd0,    0,   3,    0};
    vecs[4] = '{32'h4000_0000, 32'h0000_0100, 11'd0,    11'd5,    0,   3,    0};
    vecs[5] = '{32'h4000_0000, 32'h0100_0000, 11'd1000, 11'd300,  4,  19,  149};
    vecs[6] = '{32'h4000_0000, 32'h0100_0000, 11'd600,  11'd300,  2,  11,  149};
    pat = '{16'sd32767, 16'sd0, -16'sd32767, 16'sd0, 16'sd32767, 16'sd0, -16'sd32767};

    rst = 1'b1; tick = 1'b0; phase = '0; inc = '0; lstart = '0; lstep = '0;
    force_en = 1'b0; force_val = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      start_tick(vecs[i].phase, vecs[i].inc, vecs[i].lstart, vecs[i].lstep);
      wait_valid();
      chk($sformatf("v%0d starts", i), start_cnt - base_s, vecs[i].exp_starts);
      chk($sformatf("v%0d valids", i), valid_cnt - base_v, 1);
      chk($sformatf("v%0d latency", i), valid_cyc - t0, vecs[i].exp_lat);
      chk($sformatf("v%0d sample", i), valid_samp, vecs[i].exp_sample);
      chk($sformatf("v%0d overrun", i), ovr_cnt - base_o, 0);
      if (vecs[i].exp_starts > 0) begin
        chk($sformatf("v%0d first multiple", i), start_mult[10'(base_s)], vecs[i].lstart);
        chk($sformatf("v%0d first adder sample", i), start_samp[10'(base_s)], 32767);
      end
    end

    // Saturation with the accumulator pinned.
    force_en  = 1'b1;
    force_val = 32'h7FFF_FFFF;
    start_tick(vecs[0].phase, vecs[0].inc, vecs[0].lstart, vecs[0].lstep);
    wait_valid();
    chk("sat pos sample", valid_samp, 32767);
    force_val = 32'h8000_0000;
    start_tick(vecs[0].phase, vecs[0].inc, vecs[0].lstart, vecs[0].lstep);
    wait_valid();
    chk("sat neg sample", valid_samp, -32768);
    chk("sat neg hold", samp, -32768);
    force_en = 1'b0;

    // Second tick five cycles into a 7-harmonic sweep.
    start_tick(vecs[1].phase, vecs[1].inc, vecs[1].lstart, vecs[1].lstep);
    repeat (4) @(negedge clk);
    phase  = '0;
    inc    = 32'h0000_1000;
    lstart = 11'd5;
    tick   = 1'b1;
    t2     = cyc;
    @(negedge clk);
    tick = 1'b0;
    wait_valid();
    chk("ovr pulses", ovr_cnt - base_o, 1);
    chk("ovr timing", ovr_cyc - t2, 1);
    chk("ovr starts", start_cnt - base_s, 7);
    chk("ovr valids", valid_cnt - base_v, 1);
    chk("ovr latency", valid_cyc - t0, 31);
    chk("ovr sample", valid_samp, -1);
    for (int k = 0; k < 7; k++)
      chk($sformatf("ovr harmonic %0d adder sample", k + 1), start_samp[10'(base_s + k)], pat[k]);

    // Reset while waiting on harmonic 3.
    start_tick(vecs[1].phase, vecs[1].inc, vecs[1].lstart, vecs[1].lstep);
    n = 0;
    while (start_cnt - base_s < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst third start reached", start_cnt - base_s, 3);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("reset in wait");
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst starts after", start_cnt - base_s, 3);
    chk("rst no valid", valid_cnt - base_v, 0);

    start_tick(vecs[1].phase, vecs[1].inc, vecs[1].lstart, vecs[1].lstep);
    wait_valid();
    chk("post rst starts", start_cnt - base_s, 7);
    chk("post rst valids", valid_cnt - base_v, 1);
    chk("post rst latency", valid_cyc - t0, 31);
    chk("post rst sample", valid_samp, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
